// File: rtl/banked_sram_pkg.sv
// Shared types and address-split helpers for the banked SRAM arbiter.
package banked_sram_pkg;

    typedef enum logic {
        IDLE,
        SERVE
    } state_t;

    // Word-interleaved split: low bits pick the bank, the rest pick the row.
    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int bank_bits);
        return addr & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] row_of(input logic [31:0] addr, input int bank_bits);
        return addr >> bank_bits;
    endfunction

endpackage

// File: rtl/banked_sram_bank.sv
// One single-port bank: synchronous write, word read visible to the arbiter
// within the same cycle so the grant edge captures the pre-edge contents.
module banked_sram_bank #(
    parameter int DEPTH  = 4096,
    parameter int ROW_W  = 12,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ROW_W-1:0]  row,
    input  logic [DATA_W-1:0] wd,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[row] <= wd;
        end
    end

    assign rdata = mem[row];

endmodule

// File: rtl/banked_sram_arb.sv
// Multi-lane banked SRAM: per-bank lowest-lane grant, conflicts served over
// successive cycles. Same-word read broadcast enabled by BANKED_SRAM_BROADCAST_EN.
module banked_sram_arb
    import banked_sram_pkg::*;
#(
    parameter int NUM_LANES = 4,
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 14,
    parameter int DATA_W    = 32
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req,
    input  logic [NUM_LANES-1:0]          lane_en,
    input  logic [NUM_LANES-1:0]          we,
    input  logic [NUM_LANES*ADDR_W-1:0]   addr,
    input  logic [NUM_LANES*DATA_W-1:0]   wd,
    output logic [NUM_LANES*DATA_W-1:0]   rd,
    output logic                          busy,
    output logic                          done
);

    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int BANK_W    = (BANK_BITS > 0) ? BANK_BITS : 1;
    localparam int ROW_W     = ADDR_W - BANK_BITS;
    localparam int DEPTH     = 1 << ROW_W;

    state_t state, state_next;
    logic   done_next;

    logic [NUM_LANES-1:0] pending, we_q, lower_busy, grant, served;
    logic [ADDR_W-1:0]    addr_q     [NUM_LANES];
    logic [DATA_W-1:0]    wd_q       [NUM_LANES];
    logic [DATA_W-1:0]    rd_q       [NUM_LANES];
    logic [BANK_W-1:0]    lane_bank  [NUM_LANES];
    logic [ROW_W-1:0]     lane_row   [NUM_LANES];

    logic                 bank_en    [NUM_BANKS];
    logic                 bank_we    [NUM_BANKS];
    logic [ROW_W-1:0]     bank_row   [NUM_BANKS];
    logic [DATA_W-1:0]    bank_wd    [NUM_BANKS];
    logic [DATA_W-1:0]    bank_rdata [NUM_BANKS];

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lane_bank[i]           = BANK_W'(bank_of(32'(addr_q[i]), BANK_BITS));
        assign lane_row[i]            = ROW_W'(row_of(32'(addr_q[i]), BANK_BITS));
        assign rd[i*DATA_W +: DATA_W] = rd_q[i];
    end

    assign busy = (state == SERVE);

    // A lane wins its bank when no lower pending lane maps to the same bank.
    always_comb begin
        lower_busy = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = 0; j < i; j++) begin
                if (pending[j] && lane_bank[j] == lane_bank[i]) begin
                    lower_busy[i] = 1'b1;
                end
            end
        end
        grant = pending & ~lower_busy;
    end

`ifdef BANKED_SRAM_BROADCAST_EN
    logic [NUM_LANES-1:0] bcast_hit, bcast_blk;

    // A read rides along with a granted read of the same word, unless a lower
    // pending write to that word has to land first.
    always_comb begin
        bcast_hit = '0;
        bcast_blk = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            for (int j = 0; j < i; j++) begin
                if (addr_q[j] == addr_q[i]) begin
                    if (grant[j] && !we_q[j]) begin
                        bcast_hit[i] = 1'b1;
                    end
                    if (pending[j] && we_q[j]) begin
                        bcast_blk[i] = 1'b1;
                    end
                end
            end
        end
        served = grant | (pending & ~we_q & bcast_hit & ~bcast_blk);
    end
`else
    assign served = grant;
`endif

    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            bank_en[b]  = 1'b0;
            bank_we[b]  = 1'b0;
            bank_row[b] = '0;
            bank_wd[b]  = '0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (grant[i] && lane_bank[i] == BANK_W'(b)) begin
                    bank_en[b]  = 1'b1;
                    bank_we[b]  = we_q[i];
                    bank_row[b] = lane_row[i];
                    bank_wd[b]  = wd_q[i];
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        banked_sram_bank #(
            .DEPTH  (DEPTH),
            .ROW_W  (ROW_W),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk   (clk),
            .en    (bank_en[b]),
            .we    (bank_we[b]),
            .row   (bank_row[b]),
            .wd    (bank_wd[b]),
            .rdata (bank_rdata[b])
        );
    end

    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (|lane_en) begin
                        state_next = SERVE;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            SERVE: begin
                if ((pending & ~served) == '0) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            done    <= 1'b0;
            pending <= '0;
            we_q    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                addr_q[i] <= '0;
                wd_q[i]   <= '0;
                rd_q[i]   <= '0;
            end
        end else begin
            state <= state_next;
            done  <= done_next;
            if (state == IDLE) begin
                if (req) begin
                    pending <= lane_en;
                    we_q    <= we;
                    for (int i = 0; i < NUM_LANES; i++) begin
                        addr_q[i] <= addr[i*ADDR_W +: ADDR_W];
                        wd_q[i]   <= wd[i*DATA_W +: DATA_W];
                    end
                end
            end else begin
                pending <= pending & ~served;
                for (int i = 0; i < NUM_LANES; i++) begin
                    if (served[i] && !we_q[i]) begin
                        rd_q[i] <= bank_rdata[lane_bank[i]];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_banked_sram_arb.sv
// Self-checking bench for banked_sram_arb: vector table, hand sequences for
// conflicts/back-to-back/reset, and random requests against a lane-order model.
module tb_banked_sram_arb;

    localparam int NL = 4;
    localparam int NB = 4;
    localparam int AW = 14;
    localparam int DW = 32;
`ifdef BANKED_SRAM_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif
    localparam int SAME_WORD_EDGES = BCAST ? 1 : 4;

    typedef logic [AW-1:0] addr_arr_t [NL];
    typedef logic [DW-1:0] data_arr_t [NL];

    typedef struct {
        logic [NL-1:0] en;
        logic [NL-1:0] w;
        addr_arr_t     a;
        data_arr_t     d;
        int            edges;
        data_arr_t     exp_rd;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           req = 1'b0;
    logic [NL-1:0]  lane_en = '0;
    logic [NL-1:0]  we = '0;
    logic [NL*AW-1:0] addr = '0;
    logic [NL*DW-1:0] wd = '0;
    logic [NL*DW-1:0] rd;
    logic           busy;
    logic           done;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ref_rd [NL];
    bit            ref_known [NL];

    vec_t vecs [10];

    banked_sram_arb #(
        .NUM_LANES (NL),
        .NUM_BANKS (NB),
        .ADDR_W    (AW),
        .DATA_W    (DW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .lane_en (lane_en),
        .we      (we),
        .addr    (addr),
        .wd      (wd),
        .rd      (rd),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rd_lane(input int i);
        return rd[i*DW +: DW];
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkRd(input string tag, input data_arr_t exp_rd);
        for (int i = 0; i < NL; i++) begin
            checkOutput($sformatf("%s_rd%0d", tag, i), rd_lane(i), exp_rd[i]);
        end
    endtask

    // Reference: lanes take effect one after another in ascending order; the
    // serve time is the heaviest bank's active-lane count.
    function automatic int model_apply(input logic [NL-1:0] en, input logic [NL-1:0] w,
                                       input addr_arr_t a, input data_arr_t d);
        int cnt [NB];
        int mx = 0;
        for (int b = 0; b < NB; b++) cnt[b] = 0;
        for (int i = 0; i < NL; i++) begin
            if (en[i]) begin
                cnt[int'(a[i]) % NB]++;
                if (w[i]) begin
                    ref_mem[int'(a[i])] = d[i];
                end else if (ref_mem.exists(int'(a[i]))) begin
                    ref_rd[i]    = ref_mem[int'(a[i])];
                    ref_known[i] = 1'b1;
                end else begin
                    ref_known[i] = 1'b0;
                end
            end
        end
        for (int b = 0; b < NB; b++) if (cnt[b] > mx) mx = cnt[b];
        return mx;
    endfunction

    task automatic drive(input logic [NL-1:0] en, input logic [NL-1:0] w,
                         input addr_arr_t a, input data_arr_t d);
        lane_en = en;
        we      = w;
        for (int i = 0; i < NL; i++) begin
            addr[i*AW +: AW] = a[i];
            wd[i*DW +: DW]   = d[i];
        end
    endtask

    task automatic applyStimulus(input logic [NL-1:0] en, input logic [NL-1:0] w,
                                 input addr_arr_t a, input data_arr_t d, output int edges);
        @(negedge clk);
        req = 1'b1;
        drive(en, w, a, d);
        @(posedge clk);
        #1;
        req     = 1'b0;
        lane_en = NL'($urandom);
        we      = NL'($urandom);
        addr    = {$urandom, $urandom};
        wd      = {$urandom, $urandom, $urandom, $urandom};
        edges   = 0;
        checkOutput("busy_after_accept", busy, (en != '0) ? 1 : 0);
        while (!done && edges < 20) begin
            @(posedge clk);
            #1;
            edges++;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done expected done within 20 edges");
        end
        checkOutput("busy_at_done", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("done_one_cycle", done, 0);
    endtask

    initial begin
        int        edges;
        int        exp_edges;
        data_arr_t prev_rd, new_rd, exp_rd;
        addr_arr_t ra;
        data_arr_t rdat;
        logic [NL-1:0] ren, rw;

        vecs[0] = '{en: 4'hf, w: 4'hf, a: '{0, 5, 3, 2}, d: '{123, 456, 789, 5555},
                    edges: 1, exp_rd: '{0, 0, 0, 0}};
        vecs[1] = '{en: 4'hf, w: 4'h0, a: '{5, 2, 3, 0}, d: '{0, 0, 0, 0},
                    edges: 1, exp_rd: '{456, 5555, 789, 123}};
        vecs[2] = '{en: 4'hf, w: 4'hf, a: '{12, 8, 4, 0}, d: '{123, 456, 789, 5555},
                    edges: 4, exp_rd: '{456, 5555, 789, 123}};
        vecs[3] = '{en: 4'hf, w: 4'hf, a: '{7, 7, 7, 7}, d: '{10, 20, 30, 40},
                    edges: 4, exp_rd: '{456, 5555, 789, 123}};
        vecs[4] = '{en: 4'hf, w: 4'h0, a: '{7, 7, 7, 7}, d: '{0, 0, 0, 0},
                    edges: SAME_WORD_EDGES, exp_rd: '{40, 40, 40, 40}};
        vecs[5] = '{en: 4'h1, w: 4'h1, a: '{9, 0, 0, 0}, d: '{77, 0, 0, 0},
                    edges: 1, exp_rd: '{40, 40, 40, 40}};
        vecs[6] = '{en: 4'hf, w: 4'h0, a: '{9, 9, 9, 9}, d: '{0, 0, 0, 0},
                    edges: SAME_WORD_EDGES, exp_rd: '{77, 77, 77, 77}};
        vecs[7] = '{en: 4'b0101, w: 4'h0, a: '{0, 4, 8, 12}, d: '{0, 0, 0, 0},
                    edges: 2, exp_rd: '{5555, 77, 456, 77}};
        vecs[8] = '{en: 4'h0, w: 4'h0, a: '{1, 2, 3, 4}, d: '{9, 9, 9, 9},
                    edges: 0, exp_rd: '{5555, 77, 456, 77}};
        vecs[9] = '{en: 4'hf, w: 4'b0101, a: '{20, 20, 21, 21}, d: '{1111, 0, 2222, 0},
                    edges: 2, exp_rd: '{5555, 1111, 456, 2222}};

        for (int i = 0; i < NL; i++) begin
            ref_rd[i]    = '0;
            ref_known[i] = 1'b1;
        end

        #12;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkRd("reset", '{0, 0, 0, 0});
        @(negedge clk);
        reset = 1'b1;

        for (int v = 0; v < 10; v++) begin
            applyStimulus(vecs[v].en, vecs[v].w, vecs[v].a, vecs[v].d, edges);
            void'(model_apply(vecs[v].en, vecs[v].w, vecs[v].a, vecs[v].d));
            checkOutput($sformatf("vec%0d_edges", v), 32'(edges), 32'(vecs[v].edges));
            checkRd($sformatf("vec%0d", v), vecs[v].exp_rd);
        end

        // Full bank-0 read conflict: one lane completes per edge, lane 0 first.
        prev_rd = '{5555, 1111, 456, 2222};
        new_rd  = '{123, 456, 789, 5555};
        ra      = '{12, 8, 4, 0};
        @(negedge clk);
        req = 1'b1;
        drive(4'hf, 4'h0, ra, '{0, 0, 0, 0});
        @(posedge clk);
        #1;
        req = 1'b0;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NL; i++) exp_rd[i] = (i < e) ? new_rd[i] : prev_rd[i];
            checkRd($sformatf("conflict_e%0d", e), exp_rd);
            checkOutput($sformatf("conflict_done_e%0d", e), done, (e == 4) ? 1 : 0);
            checkOutput($sformatf("conflict_busy_e%0d", e), busy, (e == 4) ? 0 : 1);
        end
        void'(model_apply(4'hf, 4'h0, ra, '{0, 0, 0, 0}));

        // Back-to-back: the next request is held on req through the done cycle.
        @(negedge clk);
        req = 1'b1;
        drive(4'hf, 4'hf, '{40, 41, 42, 43}, '{11, 22, 33, 44});
        @(posedge clk);
        #1;
        drive(4'hf, 4'h0, '{43, 42, 41, 40}, '{0, 0, 0, 0});
        checkOutput("b2b_busy_first", busy, 1);
        @(posedge clk);
        #1;
        checkOutput("b2b_done_first", done, 1);
        @(posedge clk);
        #1;
        req = 1'b0;
        checkOutput("b2b_busy_second", busy, 1);
        checkOutput("b2b_no_done", done, 0);
        @(posedge clk);
        #1;
        checkOutput("b2b_done_second", done, 1);
        checkRd("b2b", '{44, 33, 22, 11});
        void'(model_apply(4'hf, 4'hf, '{40, 41, 42, 43}, '{11, 22, 33, 44}));
        void'(model_apply(4'hf, 4'h0, '{43, 42, 41, 40}, '{0, 0, 0, 0}));

        for (int n = 0; n < 60; n++) begin
            ren = NL'($urandom);
            rw  = NL'($urandom);
            for (int i = 0; i < NL; i++) begin
                ra[i]   = AW'($urandom_range(0, 15));
                rdat[i] = $urandom;
            end
            applyStimulus(ren, rw, ra, rdat, edges);
            exp_edges = model_apply(ren, rw, ra, rdat);
            if (!BCAST) begin
                checkOutput($sformatf("rand%0d_edges", n), 32'(edges), 32'(exp_edges));
            end
            for (int i = 0; i < NL; i++) begin
                if (ref_known[i]) begin
                    checkOutput($sformatf("rand%0d_rd%0d", n, i), rd_lane(i), ref_rd[i]);
                end
            end
        end

        // Reset after two of four conflicting writes have landed.
        @(negedge clk);
        req = 1'b1;
        drive(4'hf, 4'hf, '{100, 104, 108, 112}, '{161, 178, 195, 212});
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkRd("abort", '{0, 0, 0, 0});
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < NL; i++) begin
            ref_rd[i]    = '0;
            ref_known[i] = 1'b1;
        end
        void'(model_apply(4'b0011, 4'b0011, '{100, 104, 0, 0}, '{161, 178, 0, 0}));
        applyStimulus(4'b0011, 4'b0000, '{100, 104, 108, 112}, '{0, 0, 0, 0}, edges);
        void'(model_apply(4'b0011, 4'b0000, '{100, 104, 108, 112}, '{0, 0, 0, 0}));
        checkOutput("abort_read_edges", 32'(edges), 2);
        checkOutput("abort_read_rd0", rd_lane(0), 161);
        checkOutput("abort_read_rd1", rd_lane(1), 178);
        checkOutput("abort_read_rd2", rd_lane(2), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
